babbage_fit: RTL and testbench

BABBAGE_FIT -- requirements
Module: babbage_fit

---
 rtl/babbage_fit.sv | 171 +++++++++++++++++
 tb/tb_babbage_fit.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/babbage_fit.sv
// babbage_fit: recovers the cubic coefficients a3..a0 of y(n)=a3n^3+a2n^2+a1n+a0
// from four consecutive samples y(0)..y(3). It forms the forward differences,
// divides the third difference by 6 with a serial restoring divider, then
// back-substitutes to get the remaining coefficients.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   y [YW]       unsigned sample, captured when y_val=1 and busy=0
//   y_val        sample strobe
//   busy         high while solving; samples are ignored
//   a3..a0 [AW]  coefficients, two's-complement, low AW bits
//   valid        one-cycle pulse marking a new coefficient set
//   err          inexact-fit flag, qualified by valid
//
// Configuration macro BABBAGE_FIT_EXACT_CHECK_EN: when defined, err flags a
// nonzero remainder, an odd (D2-D3), or a coefficient that does not fit in
// signed AW bits. When undefined, err is tied to 0 and no check logic exists.

module babbage_fit #(
   parameter int unsigned YW = 33,
   parameter int unsigned AW = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [YW-1:0] y,
   input  logic          y_val,
   output logic          busy,
   output logic [AW-1:0] a3,
   output logic [AW-1:0] a2,
   output logic [AW-1:0] a1,
   output logic [AW-1:0] a0,
   output logic          valid,
   output logic          err
);

   localparam int unsigned W  = YW + 3;           // difference width (signed)
   localparam int unsigned IW = YW + 5;           // back-substitution width
   localparam int unsigned CW = $clog2(W + 1);    // divide-step counter width

   typedef enum logic [1:0] {COLLECT, DIV, SOLVE, OUT} state_t;

   state_t               state;
   logic [1:0]           count;
   logic [YW-1:0]        s [4];
   logic signed [W-1:0]  d1, d2, d3;
   logic [W-1:0]         dq;      // dividend shifted out MSB-first, quotient shifted in
   logic [2:0]           rem;     // partial remainder, always < 6
   logic [CW-1:0]        cnt;

   // Forward differences formed from the stored samples and the 4th sample on the bus
   logic signed [W-1:0]  ye, s0e, s1e, s2e;
   logic signed [W-1:0]  d1_c, d2_c, d3_c;
   logic [W-1:0]         d3_abs_c;

   always_comb begin
      ye       = W'(y);
      s0e      = W'(s[0]);
      s1e      = W'(s[1]);
      s2e      = W'(s[2]);
      d1_c     = s1e - s0e;
      d2_c     = s2e - (s1e <<< 1) + s0e;
      d3_c     = ye - (s2e <<< 1) - s2e + (s1e <<< 1) + s1e - s0e;
      d3_abs_c = d3_c[W-1] ? W'(-d3_c) : W'(d3_c);
   end

   // One restoring-division step by 6
   logic [3:0] rsh_c;
   logic       ge_c;
   logic [2:0] rem_nx_c;

   always_comb begin
      rsh_c    = {rem, dq[W-1]};
      ge_c     = (rsh_c >= 4'd6);
      rem_nx_c = ge_c ? 3'(rsh_c - 4'd6) : 3'(rsh_c);
   end

   // Back-substitution at full internal width
   logic signed [IW-1:0] q_ext_c, q3_c, diff_c, a2_c, a1_c, a0_c;

   always_comb begin
      q_ext_c = IW'(dq);
      q3_c    = d3[W-1] ? -q_ext_c : q_ext_c;   // truncation toward zero
      diff_c  = IW'(d2) - IW'(d3);
      a2_c    = diff_c >>> 1;
      a1_c    = IW'(d1) - q3_c - a2_c;
      a0_c    = IW'(s[0]);
   end

`ifdef BABBAGE_FIT_EXACT_CHECK_EN
   // True when x is a sign extension of its low AW bits
   function automatic logic fits(input logic [IW-1:0] x);
      logic [IW-AW:0] top;
      top = x[IW-1:AW-1];
      return (&top) | (~|top);
   endfunction

   logic err_c;

   always_comb begin
      err_c = (rem != 3'd0) | diff_c[0]
            | ~fits(q3_c) | ~fits(a2_c) | ~fits(a1_c) | ~fits(a0_c);
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= COLLECT;
         count <= 2'd0;
         for (int i = 0; i < 4; i++) s[i] <= '0;
         d1    <= '0;
         d2    <= '0;
         d3    <= '0;
         dq    <= '0;
         rem   <= '0;
         cnt   <= '0;
         a3    <= '0;
         a2    <= '0;
         a1    <= '0;
         a0    <= '0;
         valid <= 1'b0;
         busy  <= 1'b0;
         err   <= 1'b0;
      end else begin
         valid <= 1'b0;
         case (state)
            COLLECT: begin
               if (y_val) begin
                  s[count] <= y;
                  count    <= count + 2'd1;
                  if (count == 2'd3) begin
                     d1    <= d1_c;
                     d2    <= d2_c;
                     d3    <= d3_c;
                     dq    <= d3_abs_c;
                     rem   <= '0;
                     cnt   <= '0;
                     busy  <= 1'b1;
                     state <= DIV;
                  end
               end
            end
            DIV: begin
               dq  <= {dq[W-2:0], ge_c};
               rem <= rem_nx_c;
               cnt <= cnt + CW'(1);
               if (cnt == CW'(W - 1)) state <= SOLVE;
            end
            SOLVE: begin
               a3    <= AW'(q3_c);
               a2    <= AW'(a2_c);
               a1    <= AW'(a1_c);
               a0    <= AW'(a0_c);
`ifdef BABBAGE_FIT_EXACT_CHECK_EN
               err   <= err_c;
`else
               err   <= 1'b0;
`endif
               valid <= 1'b1;
               state <= OUT;
            end
            OUT: begin
               busy  <= 1'b0;
               count <= 2'd0;
               state <= COLLECT;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_babbage_fit.sv
// Self-checking bench for babbage_fit: directed sample sets with hand-computed
// coefficients, latency and busy-length checks, busy-time y_val flooding,
// and a reset abort in the middle of the divide.

module tb_babbage_fit;

   localparam int unsigned YW = 33;
   localparam int unsigned AW = 8;

`ifdef BABBAGE_FIT_EXACT_CHECK_EN
   localparam logic ERR_EN = 1'b1;
`else
   localparam logic ERR_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic [YW-1:0] y;
   logic          y_val;
   logic          busy;
   logic [AW-1:0] a3, a2, a1, a0;
   logic          valid;
   logic          err;

   int n_checks = 0;
   int n_errors = 0;

   int vk, bk, np;

   babbage_fit #(.YW(YW), .AW(AW)) dut (
      .clk   (clk),
      .rst   (rst),
      .y     (y),
      .y_val (y_val),
      .busy  (busy),
      .a3    (a3),
      .a2    (a2),
      .a1    (a1),
      .a0    (a0),
      .valid (valid),
      .err   (err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Drives four samples on consecutive cycles, then observes 45 cycles.
   // vk: cycle (after the 4th acceptance) of the first valid; bk: busy cycles;
   // np: valid cycles. flood keeps y_val=1 (y=99) while busy; abort_at>0
   // pulses rst in that cycle.
   task automatic run_set(input logic [YW-1:0] v0, input logic [YW-1:0] v1,
                          input logic [YW-1:0] v2, input logic [YW-1:0] v3,
                          input bit flood, input int abort_at,
                          output int vk_o, output int bk_o, output int np_o);
      logic [YW-1:0] v [4];
      v[0] = v0; v[1] = v1; v[2] = v2; v[3] = v3;
      vk_o = 0; bk_o = 0; np_o = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         y     = v[i];
         y_val = 1'b1;
      end
      for (int k = 1; k <= 45; k++) begin
         @(negedge clk);
         if (valid) begin
            np_o++;
            if (vk_o == 0) vk_o = k;
         end
         if (busy) bk_o++;
         rst   = (k == abort_at);
         y_val = flood && busy;
         y     = YW'(99);
      end
      y_val = 1'b0;
      rst   = 1'b0;
   endtask

   task automatic check_coef(input string tag, input logic [7:0] e3, input logic [7:0] e2,
                             input logic [7:0] e1, input logic [7:0] e0);
      check({tag, ".a3"}, 64'(a3), 64'(e3));
      check({tag, ".a2"}, 64'(a2), 64'(e2));
      check({tag, ".a1"}, 64'(a1), 64'(e1));
      check({tag, ".a0"}, 64'(a0), 64'(e0));
   endtask

   initial begin
      // Reset with y_val asserted: reset must win and store nothing
      rst   = 1'b1;
      y_val = 1'b1;
      y     = YW'(5);
      repeat (3) @(negedge clk);
      check("rst.busy",  64'(busy),  64'd0);
      check("rst.valid", 64'(valid), 64'd0);
      check("rst.err",   64'(err),   64'd0);
      check_coef("rst", 8'h00, 8'h00, 8'h00, 8'h00);
      rst   = 1'b0;
      y_val = 1'b0;

      // 1,2,3,4 coefficients
      run_set(4, 10, 26, 58, 1'b0, 0, vk, bk, np);
      check("a.latency", 64'(vk), 64'd38);
      check("a.busylen", 64'(bk), 64'd38);
      check("a.pulses",  64'(np), 64'd1);
      check_coef("a", 8'h01, 8'h02, 8'h03, 8'h04);
      check("a.err", 64'(err), 64'd0);
      repeat (5) @(negedge clk);
      check("a.hold.a3", 64'(a3), 64'd1);
      check("a.hold.a1", 64'(a1), 64'd3);

      // All-zero samples
      run_set(0, 0, 0, 0, 1'b0, 0, vk, bk, np);
      check("z.busylen", 64'(bk), 64'd38);
      check("z.latency", 64'(vk), 64'd38);
      check_coef("z", 8'h00, 8'h00, 8'h00, 8'h00);
      check("z.err", 64'(err), 64'd0);

      // Inexact fit: D3=3 leaves remainder 3, D2-D3=-5 is odd
      run_set(0, 1, 0, 0, 1'b0, 0, vk, bk, np);
      check_coef("inx", 8'h00, 8'hFD, 8'h04, 8'h00);
      check("inx.err", 64'(err), 64'(ERR_EN));

      // y_val held high with junk through busy and OUT
      run_set(4, 10, 26, 58, 1'b1, 0, vk, bk, np);
      check("fl.latency", 64'(vk), 64'd38);
      check("fl.pulses",  64'(np), 64'd1);
      check_coef("fl", 8'h01, 8'h02, 8'h03, 8'h04);
      check("fl.err", 64'(err), 64'd0);
      run_set(1, 2, 3, 4, 1'b0, 0, vk, bk, np);
      check_coef("fl.next", 8'h00, 8'h00, 8'h01, 8'h01);

      // Reset in DIV cycle 10 aborts the set
      run_set(255, 1020, 3825, 10200, 1'b0, 10, vk, bk, np);
      check("ab.pulses", 64'(np), 64'd0);
      check("ab.busylen", 64'(bk), 64'd10);
      check("ab.busy",  64'(busy),  64'd0);
      check_coef("ab", 8'h00, 8'h00, 8'h00, 8'h00);
      run_set(1, 2, 3, 4, 1'b0, 0, vk, bk, np);
      check("ab.next.pulses", 64'(np), 64'd1);
      check("ab.next.latency", 64'(vk), 64'd38);
      check_coef("ab.next", 8'h00, 8'h00, 8'h01, 8'h01);

      // Coefficients of 255 overflow signed 8 bits
      run_set(255, 1020, 3825, 10200, 1'b0, 0, vk, bk, np);
      check_coef("ovf", 8'hFF, 8'hFF, 8'hFF, 8'hFF);
      check("ovf.err", 64'(err), 64'(ERR_EN));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
